// File: rtl/peripheral_biu_pkg.sv
// Shared bus-interface encodings (size, burst type, protection) and the
// single-transaction master FSM state type.
package peripheral_biu_pkg;

    typedef enum logic [2:0] {
        SIZE_BYTE  = 3'b000,
        SIZE_HWORD = 3'b001,
        SIZE_WORD  = 3'b010,
        SIZE_DWORD = 3'b011,
        SIZE_QWORD = 3'b100
    } biu_size_t;

    typedef enum logic [2:0] {
        BT_SINGLE = 3'b000,
        BT_INCR   = 3'b001,
        BT_WRAP4  = 3'b010,
        BT_INCR4  = 3'b011,
        BT_WRAP8  = 3'b100,
        BT_INCR8  = 3'b101,
        BT_WRAP16 = 3'b110,
        BT_INCR16 = 3'b111
    } biu_type_t;

    // Protection is a bit mask, not an enumeration.
    localparam logic [2:0] PROT_DATA        = 3'b000;
    localparam logic [2:0] PROT_PRIVILEGED  = 3'b001;
    localparam logic [2:0] PROT_NONSECURE   = 3'b010;
    localparam logic [2:0] PROT_INSTRUCTION = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_STB  = 2'b01,
        ST_WAIT = 2'b10
    } mpram_tl_state_t;

    function automatic logic state_is_busy(input mpram_tl_state_t st);
        return (st == ST_STB) || (st == ST_WAIT);
    endfunction

endpackage

// File: rtl/peripheral_mpram_tl_timeout.sv
// Response-timeout counter for the MPRAM TL master; only compiled when
// PERIPHERAL_MPRAM_TIMEOUT_EN is defined.
`ifdef PERIPHERAL_MPRAM_TIMEOUT_EN
module peripheral_mpram_tl_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);
    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] r_count;

    // Cycle counter: restarts at each new strobe, saturates at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 16'd0;
        end else if (i_clear) begin
            r_count <= 16'd0;
        end else if (i_en && (r_count != LIMIT)) begin
            r_count <= r_count + 16'd1;
        end
    end

    // Fires during the TIMEOUT-th busy cycle so the registered err lands on the next.
    assign o_expired = i_en && (r_count == LIMIT);

endmodule
`endif

// File: rtl/peripheral_mpram_tl_master.sv
// Single-outstanding bus master bridging a core request port to the BIU.
// Optional response timeout enabled by PERIPHERAL_MPRAM_TIMEOUT_EN.
module peripheral_mpram_tl_master
    import peripheral_biu_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int PLEN    = 64,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_i,
    input  logic            we_i,
    input  logic [2:0]      size_i,
    input  logic [2:0]      prot_i,
    input  logic            lock_i,
    input  logic [PLEN-1:0] addr_i,
    input  logic [XLEN-1:0] data_i,
    output logic            ready_o,
    output logic [XLEN-1:0] data_o,
    output logic            ack_o,
    output logic            err_o,
    output logic            biu_stb_o,
    input  logic            biu_stb_ack_i,
    input  logic            biu_d_ack_i,
    output logic [PLEN-1:0] biu_adri_o,
    input  logic [PLEN-1:0] biu_adro_i,
    output logic [2:0]      biu_size_o,
    output logic [2:0]      biu_type_o,
    output logic [2:0]      biu_prot_o,
    output logic            biu_lock_o,
    output logic            biu_we_o,
    output logic [XLEN-1:0] biu_d_o,
    input  logic [XLEN-1:0] biu_q_i,
    input  logic            biu_ack_i,
    input  logic            biu_err_i
);
    mpram_tl_state_t r_state, w_next_state;

    logic            r_stb, r_we, r_lock, r_ack, r_err;
    logic [PLEN-1:0] r_adr;
    logic [2:0]      r_size, r_prot;
    logic [XLEN-1:0] r_d, r_data;

    logic w_busy, w_accept, w_ack_evt, w_err_evt, w_drop_stb, w_capture;
    logic w_timeout;

    logic w_unused_inputs;
    assign w_unused_inputs = biu_d_ack_i ^ (^biu_adro_i);

`ifdef PERIPHERAL_MPRAM_TIMEOUT_EN
    peripheral_mpram_tl_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_accept),
        .i_en      (w_busy),
        .o_expired (w_timeout)
    );
`else
    logic [15:0] w_unused_timeout;
    assign w_unused_timeout = 16'(TIMEOUT);
    assign w_timeout        = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; completion (ack/err/timeout) from STB skips WAIT.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_i) w_next_state = ST_STB;
                else       w_next_state = ST_IDLE;
            end
            ST_STB: begin
                if (w_ack_evt || w_err_evt) w_next_state = ST_IDLE;
                else if (biu_stb_ack_i)     w_next_state = ST_WAIT;
                else                        w_next_state = ST_STB;
            end
            ST_WAIT: begin
                if (w_ack_evt || w_err_evt) w_next_state = ST_IDLE;
                else                        w_next_state = ST_WAIT;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output decode; err beats a simultaneous ack, while ack beats a timeout.
    always_comb begin
        w_busy     = state_is_busy(r_state);
        w_accept   = (r_state == ST_IDLE) && req_i;
        w_err_evt  = w_busy && (biu_err_i || (w_timeout && !biu_ack_i));
        w_ack_evt  = w_busy && biu_ack_i && !biu_err_i;
        w_drop_stb = (r_state == ST_STB) && (biu_stb_ack_i || w_ack_evt || w_err_evt);
        w_capture  = w_ack_evt && !r_we;
    end

    // Output registers: request fields latched on accept, held until next accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stb  <= 1'b0;
            r_we   <= 1'b0;
            r_lock <= 1'b0;
            r_adr  <= {PLEN{1'b0}};
            r_size <= 3'b000;
            r_prot <= 3'b000;
            r_d    <= {XLEN{1'b0}};
            r_data <= {XLEN{1'b0}};
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_ack <= w_ack_evt;
            r_err <= w_err_evt;
            if (w_accept) begin
                r_stb  <= 1'b1;
                r_we   <= we_i;
                r_lock <= lock_i;
                r_adr  <= addr_i;
                r_size <= size_i;
                r_prot <= prot_i;
                r_d    <= data_i;
            end else if (w_drop_stb) begin
                r_stb <= 1'b0;
            end
            if (w_capture) begin
                r_data <= biu_q_i;
            end
        end
    end

    assign ready_o    = (r_state == ST_IDLE);
    assign data_o     = r_data;
    assign ack_o      = r_ack;
    assign err_o      = r_err;
    assign biu_stb_o  = r_stb;
    assign biu_adri_o = r_adr;
    assign biu_size_o = r_size;
    assign biu_type_o = BT_SINGLE;
    assign biu_prot_o = r_prot;
    assign biu_lock_o = r_lock;
    assign biu_we_o   = r_we;
    assign biu_d_o    = r_d;

endmodule

// File: tb/tb_peripheral_mpram_tl_master.sv
// Directed bench for peripheral_mpram_tl_master (timeout path checked when
// PERIPHERAL_MPRAM_TIMEOUT_EN is defined, indefinite wait otherwise).
module tb_peripheral_mpram_tl_master;
    localparam int XLEN = 64;
    localparam int PLEN = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            req_i = 1'b0, we_i = 1'b0, lock_i = 1'b0;
    logic [2:0]      size_i = 3'd0, prot_i = 3'd0;
    logic [PLEN-1:0] addr_i = '0;
    logic [XLEN-1:0] data_i = '0;
    logic            ready_o, ack_o, err_o;
    logic [XLEN-1:0] data_o;
    logic            biu_stb_o, biu_lock_o, biu_we_o;
    logic            biu_stb_ack_i = 1'b0, biu_d_ack_i = 1'b0;
    logic            biu_ack_i = 1'b0, biu_err_i = 1'b0;
    logic [PLEN-1:0] biu_adri_o, biu_adro_i = '0;
    logic [2:0]      biu_size_o, biu_type_o, biu_prot_o;
    logic [XLEN-1:0] biu_d_o, biu_q_i = '0;

    int checks = 0;
    int errors = 0;

    peripheral_mpram_tl_master #(.XLEN(XLEN), .PLEN(PLEN), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req_i(req_i), .we_i(we_i), .size_i(size_i), .prot_i(prot_i),
        .lock_i(lock_i), .addr_i(addr_i), .data_i(data_i),
        .ready_o(ready_o), .data_o(data_o), .ack_o(ack_o), .err_o(err_o),
        .biu_stb_o(biu_stb_o), .biu_stb_ack_i(biu_stb_ack_i),
        .biu_d_ack_i(biu_d_ack_i), .biu_adri_o(biu_adri_o),
        .biu_adro_i(biu_adro_i), .biu_size_o(biu_size_o),
        .biu_type_o(biu_type_o), .biu_prot_o(biu_prot_o),
        .biu_lock_o(biu_lock_o), .biu_we_o(biu_we_o), .biu_d_o(biu_d_o),
        .biu_q_i(biu_q_i), .biu_ack_i(biu_ack_i), .biu_err_i(biu_err_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_stb", biu_stb_o, 1'b0);
        check("rst_ack", ack_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_data", data_o, 64'h0);
        check("rst_adr", biu_adri_o, 64'h0);
        tick();
        rst = 1'b1;
        tick();
        check("rel_ready", ready_o, 1'b1);
        check("rel_type", biu_type_o, 3'b000);

        // Read: stb_ack after 2 cycles, ack 3 cycles later
        req_i = 1'b1; we_i = 1'b0; addr_i = 64'h40; size_i = 3'b010; prot_i = 3'b001;
        tick();
        req_i = 1'b0; addr_i = 64'h999;
        check("rd_stb_rise", biu_stb_o, 1'b1);
        check("rd_ready_low", ready_o, 1'b0);
        check("rd_adr", biu_adri_o, 64'h40);
        check("rd_we", biu_we_o, 1'b0);
        check("rd_size", biu_size_o, 3'b010);
        check("rd_prot", biu_prot_o, 3'b001);
        tick();
        check("rd_stb_hold", biu_stb_o, 1'b1);
        check("rd_adr_hold", biu_adri_o, 64'h40);
        biu_stb_ack_i = 1'b1;
        tick();
        biu_stb_ack_i = 1'b0;
        check("rd_stb_drop", biu_stb_o, 1'b0);
        check("rd_no_early_ack", ack_o, 1'b0);
        tick();
        tick();
        biu_ack_i = 1'b1; biu_q_i = 64'hDEADBEEF;
        tick();
        biu_ack_i = 1'b0; biu_q_i = 64'h0;
        check("rd_ack", ack_o, 1'b1);
        check("rd_err", err_o, 1'b0);
        check("rd_data", data_o, 64'hDEADBEEF);
        check("rd_ready", ready_o, 1'b1);
        tick();
        check("rd_ack_pulse", ack_o, 1'b0);

        // Write with stb_ack and ack in the same cycle
        req_i = 1'b1; we_i = 1'b1; addr_i = 64'h80; data_i = 64'h1234;
        tick();
        req_i = 1'b0; we_i = 1'b0;
        check("wr_stb", biu_stb_o, 1'b1);
        check("wr_we", biu_we_o, 1'b1);
        check("wr_d", biu_d_o, 64'h1234);
        check("wr_adr", biu_adri_o, 64'h80);
        biu_stb_ack_i = 1'b1; biu_ack_i = 1'b1; biu_q_i = 64'h5555;
        tick();
        biu_stb_ack_i = 1'b0; biu_ack_i = 1'b0;
        check("wr_stb_one", biu_stb_o, 1'b0);
        check("wr_ack", ack_o, 1'b1);
        check("wr_data_kept", data_o, 64'hDEADBEEF);
        check("wr_ready", ready_o, 1'b1);
        tick();
        check("wr_ack_pulse", ack_o, 1'b0);

        // err + ack together in WAIT
        req_i = 1'b1; addr_i = 64'h100;
        tick();
        req_i = 1'b0;
        biu_stb_ack_i = 1'b1;
        tick();
        biu_stb_ack_i = 1'b0;
        check("er_wait_ready", ready_o, 1'b0);
        biu_ack_i = 1'b1; biu_err_i = 1'b1; biu_q_i = 64'h77;
        tick();
        biu_ack_i = 1'b0; biu_err_i = 1'b0;
        check("er_err", err_o, 1'b1);
        check("er_ack", ack_o, 1'b0);
        check("er_data_kept", data_o, 64'hDEADBEEF);
        check("er_idle", ready_o, 1'b1);
        tick();
        check("er_err_pulse", err_o, 1'b0);

        // Responses in IDLE are ignored
        biu_ack_i = 1'b1; biu_err_i = 1'b1;
        tick();
        biu_ack_i = 1'b0; biu_err_i = 1'b0;
        check("idle_ack", ack_o, 1'b0);
        check("idle_err", err_o, 1'b0);
        check("idle_data", data_o, 64'hDEADBEEF);

        // Silent slave
        req_i = 1'b1; addr_i = 64'h140;
        tick();
        req_i = 1'b0;
        check("to_stb_rise", biu_stb_o, 1'b1);
`ifdef PERIPHERAL_MPRAM_TIMEOUT_EN
        for (int i = 1; i < 8; i++) begin
            tick();
            check("to_no_err", err_o, 1'b0);
            check("to_stb_held", biu_stb_o, 1'b1);
        end
        tick();
        check("to_err", err_o, 1'b1);
        check("to_stb_drop", biu_stb_o, 1'b0);
        check("to_ack", ack_o, 1'b0);
        check("to_ready", ready_o, 1'b1);
        tick();
        check("to_err_pulse", err_o, 1'b0);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            check("hold_stb", biu_stb_o, 1'b1);
            check("hold_err", err_o, 1'b0);
        end
        biu_stb_ack_i = 1'b1; biu_ack_i = 1'b1; biu_q_i = 64'hABCD;
        tick();
        biu_stb_ack_i = 1'b0; biu_ack_i = 1'b0;
        check("hold_done_ack", ack_o, 1'b1);
        check("hold_done_data", data_o, 64'hABCD);
        tick();
`endif

        // Reset during WAIT
        req_i = 1'b1; addr_i = 64'h180;
        tick();
        req_i = 1'b0;
        biu_stb_ack_i = 1'b1;
        tick();
        biu_stb_ack_i = 1'b0;
        biu_ack_i = 1'b1; biu_q_i = 64'h1111;
        rst = 1'b0;
        #1;
        check("ar_stb", biu_stb_o, 1'b0);
        check("ar_data", data_o, 64'h0);
        check("ar_adr", biu_adri_o, 64'h0);
        check("ar_ack", ack_o, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        biu_ack_i = 1'b0;
        check("ar_rel_ack", ack_o, 1'b0);
        check("ar_rel_err", err_o, 1'b0);
        check("ar_rel_ready", ready_o, 1'b1);
        check("ar_rel_data", data_o, 64'h0);
        tick();
        check("ar_rel_ack2", ack_o, 1'b0);

        // Next request completes normally
        req_i = 1'b1; addr_i = 64'h200;
        tick();
        req_i = 1'b0;
        check("nx_stb", biu_stb_o, 1'b1);
        check("nx_adr", biu_adri_o, 64'h200);
        biu_stb_ack_i = 1'b1; biu_ack_i = 1'b1; biu_q_i = 64'hCAFE;
        tick();
        biu_stb_ack_i = 1'b0; biu_ack_i = 1'b0;
        check("nx_ack", ack_o, 1'b1);
        check("nx_data", data_o, 64'hCAFE);
        check("nx_stb_drop", biu_stb_o, 1'b0);
        tick();
        check("nx_ack_pulse", ack_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
